// File: rtl/rr_arb_mux_if.sv
// ---------------------------------------------------------------------------
// rr_arb_mux_if
//
// Purpose: bundles the source-side and master-side handshake/bus signals of
// the round-robin burst arbiter so they travel as one port.
//
// Signals:
//   s_valid   [N_SRC]            per-source beat valid (bit i = source i)
//   s_last    [N_SRC]            per-source last beat of burst
//   s_payload [N_SRC*PAYLOAD_W]  source i payload in [i*PAYLOAD_W +: PAYLOAD_W]
//   s_ready   [N_SRC]            per-source ready, at most one bit high
//   m_valid                      selected beat valid
//   m_ready                      downstream accepts beat
//   m_payload [PAYLOAD_W]        selected payload
//   m_last                       selected last flag
//   m_sel     [SEL_W]            granted source index, 0 when nothing granted
//
// Modports:
//   slave  - the arbiter's view: it receives the source traffic and the
//            downstream ready, and produces the muxed beat.
//   master - the environment's view: it drives source traffic and ready.
// ---------------------------------------------------------------------------
interface rr_arb_mux_if #(
    parameter int N_SRC     = 6,
    parameter int PAYLOAD_W = 32
);
    localparam int SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [N_SRC-1:0]           s_valid;
    logic [N_SRC-1:0]           s_last;
    logic [N_SRC*PAYLOAD_W-1:0] s_payload;
    logic [N_SRC-1:0]           s_ready;
    logic                       m_valid;
    logic                       m_ready;
    logic [PAYLOAD_W-1:0]       m_payload;
    logic                       m_last;
    logic [SEL_W-1:0]           m_sel;

    modport slave (
        input  s_valid,
        input  s_last,
        input  s_payload,
        input  m_ready,
        output s_ready,
        output m_valid,
        output m_payload,
        output m_last,
        output m_sel
    );

    modport master (
        output s_valid,
        output s_last,
        output s_payload,
        output m_ready,
        input  s_ready,
        input  m_valid,
        input  m_payload,
        input  m_last,
        input  m_sel
    );
endinterface

// File: rtl/rr_arb_mux.sv
// ---------------------------------------------------------------------------
// rr_arb_mux
//
// Purpose: round-robin arbiter and multiplexer for N_SRC burst sources. A
// source that wins arbitration is locked in until it sends a beat flagged
// last, or until MAX_BEATS beats have gone through without a last, in which
// case the grant is forcibly released and err_timeout pulses for one cycle.
// After every release the arbiter spends one IDLE cycle re-arbitrating, and
// the search starts just after the most recently released source.
//
// Ports:
//   ACLK         sole clock, rising edge
//   ARESET       synchronous active-high reset
//   bus          rr_arb_mux_if.slave (source beats in, muxed beat out)
//   busy         high while a grant is held
//   err_timeout  one-cycle pulse after a forced (no-last) release
//
// Parameters:
//   N_SRC      number of sources, 2..8
//   PAYLOAD_W  payload width per source
//   MAX_BEATS  beat limit per locked burst, 1..255
// ---------------------------------------------------------------------------
module rr_arb_mux #(
    parameter int N_SRC     = 6,
    parameter int PAYLOAD_W = 32,
    parameter int MAX_BEATS = 16
) (
    input  logic        ACLK,
    input  logic        ARESET,
    rr_arb_mux_if.slave bus,
    output logic        busy,
    output logic        err_timeout
);

    localparam int               SEL_W     = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [7:0]       LAST_BEAT = 8'(MAX_BEATS - 1);
    localparam logic [SEL_W-1:0] LAST_SRC  = SEL_W'(N_SRC - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0] last_gnt_q, last_gnt_d;
    logic [7:0]       beats_q, beats_d;
    logic             err_timeout_q, err_timeout_d;

    logic [N_SRC-1:0] upper_mask;
    logic [N_SRC-1:0] req_upper;
    logic [SEL_W-1:0] first_upper;
    logic [SEL_W-1:0] first_any;
    logic [SEL_W-1:0] winner;
    logic             any_req;
    logic             xfer;

    // Round-robin winner selection. Rather than rotating the request vector,
    // the requests are split into those strictly above last_gnt and the rest.
    // The lowest requester above last_gnt wins if there is one; otherwise the
    // search has wrapped around and the lowest requester overall wins. This
    // is the same as scanning last_gnt+1, last_gnt+2, ... modulo N_SRC.
    always_comb begin
        upper_mask  = '0;
        first_upper = '0;
        first_any   = '0;
        for (int i = 0; i < N_SRC; i++) begin
            upper_mask[i] = (i > int'(last_gnt_q));
        end
        req_upper = bus.s_valid & upper_mask;
        any_req   = |bus.s_valid;
        // Scan downward so the lowest set index is the one left standing.
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req_upper[i]) begin
                first_upper = SEL_W'(i);
            end
            if (bus.s_valid[i]) begin
                first_any = SEL_W'(i);
            end
        end
        winner = (|req_upper) ? first_upper : first_any;
    end

    // Datapath mux. Only the granted source is ever looked at, so nothing
    // from an ungranted source (including X on its payload) can leak onto
    // the master side. While IDLE every output sits at zero and no beat can
    // transfer because no s_ready bit is raised.
    always_comb begin
        bus.m_valid   = 1'b0;
        bus.m_last    = 1'b0;
        bus.m_payload = '0;
        bus.s_ready   = '0;
        bus.m_sel     = '0;
        if (state_q == LOCKED) begin
            bus.m_sel = gnt_q;
            for (int i = 0; i < N_SRC; i++) begin
                if (gnt_q == SEL_W'(i)) begin
                    bus.m_valid   = bus.s_valid[i];
                    bus.m_last    = bus.s_last[i];
                    bus.m_payload = bus.s_payload[i*PAYLOAD_W +: PAYLOAD_W];
                    bus.s_ready[i] = bus.m_ready;
                end
            end
        end
    end

    // A beat moves whenever the muxed valid meets the downstream ready.
    always_comb begin
        xfer        = bus.m_valid & bus.m_ready;
        busy        = (state_q == LOCKED);
        err_timeout = err_timeout_q;
    end

    // Next-state logic. In IDLE the winner is captured and the beat count is
    // cleared. In LOCKED the grant is frozen no matter what the sources do;
    // only transfers matter. A last beat releases normally even if it also
    // happens to be the MAX_BEATS-th beat, so the timeout flag is reserved
    // for bursts that genuinely overran. The timeout flag defaults low so it
    // can only ever be high for the single cycle after a forced release.
    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        last_gnt_d    = last_gnt_q;
        beats_d       = beats_q;
        err_timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt_d   = winner;
                    beats_d = '0;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (xfer) begin
                    beats_d = beats_q + 8'd1;
                    if (bus.m_last) begin
                        state_d    = IDLE;
                        last_gnt_d = gnt_q;
                    end else if (beats_q == LAST_BEAT) begin
                        state_d       = IDLE;
                        last_gnt_d    = gnt_q;
                        err_timeout_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers. Reset wins over everything, aborts any burst without
    // raising the timeout flag, and parks last_gnt on the highest source so
    // the first arbitration after reset starts its scan at source 0.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q       <= IDLE;
            gnt_q         <= '0;
            last_gnt_q    <= LAST_SRC;
            beats_q       <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            last_gnt_q    <= last_gnt_d;
            beats_q       <= beats_d;
            err_timeout_q <= err_timeout_d;
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// ---------------------------------------------------------------------------
// tb_rr_arb_mux
//
// Exercises two arbiter instances: a six-source, 32-bit instance with a
// four-beat limit (directed scenarios followed by random traffic, all checked
// cycle by cycle against a behavioural model), and a two-source, 8-bit
// instance showing simple alternation.
// ---------------------------------------------------------------------------
module tb_rr_arb_mux;

    localparam int NA = 6;
    localparam int WA = 32;
    localparam int MA = 4;
    localparam int NB = 2;
    localparam int WB = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;
    logic busy_a, err_a;
    logic busy_b, err_b;

    rr_arb_mux_if #(.N_SRC(NA), .PAYLOAD_W(WA)) bus_a ();
    rr_arb_mux_if #(.N_SRC(NB), .PAYLOAD_W(WB)) bus_b ();

    rr_arb_mux #(.N_SRC(NA), .PAYLOAD_W(WA), .MAX_BEATS(MA)) dut_a (
        .ACLK        (clk),
        .ARESET      (rst_a),
        .bus         (bus_a),
        .busy        (busy_a),
        .err_timeout (err_a)
    );

    rr_arb_mux #(.N_SRC(NB), .PAYLOAD_W(WB), .MAX_BEATS(16)) dut_b (
        .ACLK        (clk),
        .ARESET      (rst_b),
        .bus         (bus_b),
        .busy        (busy_b),
        .err_timeout (err_b)
    );

    int check_count = 0;
    int fail_count  = 0;

    // Behavioural model of instance A: whether a burst is held, by whom,
    // how many beats it has moved, who was released last, and whether a
    // timeout pulse is due this cycle.
    bit model_ok   = 1'b0;
    bit mdl_locked = 1'b0;
    int mdl_gnt    = 0;
    int mdl_last   = NA - 1;
    int mdl_beats  = 0;
    bit mdl_err    = 1'b0;

    logic [NA*WA-1:0] pay_next;
    int grant_log[$];
    int busy_log[$];
    bit prev_busy_a = 1'b0;
    int err_seen    = 0;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Compare every instance-A output against the model for the current cycle
    // and keep the grant/busy history used by the directed scenarios.
    task automatic checkModelA();
        logic [NA*WA-1:0] pay;
        logic [NA-1:0]    exp_ready;
        logic [WA-1:0]    exp_pay;
        logic             exp_valid;
        logic             exp_last;
        pay = bus_a.s_payload;
        if (busy_a === 1'b1 && !prev_busy_a) begin
            grant_log.push_back(int'(bus_a.m_sel));
        end
        prev_busy_a = (busy_a === 1'b1);
        busy_log.push_back((busy_a === 1'b1) ? 1 : 0);
        if (err_a === 1'b1) begin
            err_seen++;
        end
        if (model_ok) begin
            exp_ready = '0;
            exp_pay   = '0;
            exp_valid = 1'b0;
            exp_last  = 1'b0;
            if (mdl_locked) begin
                exp_ready[mdl_gnt] = bus_a.m_ready;
                exp_pay   = pay[mdl_gnt*WA +: WA];
                exp_valid = bus_a.s_valid[mdl_gnt];
                exp_last  = bus_a.s_last[mdl_gnt];
            end
            checkOutput("busy",        64'(busy_a),          64'(mdl_locked));
            checkOutput("m_sel",       64'(bus_a.m_sel),     64'(mdl_locked ? mdl_gnt : 0));
            checkOutput("m_valid",     64'(bus_a.m_valid),   64'(exp_valid));
            checkOutput("m_last",      64'(bus_a.m_last),    64'(exp_last));
            checkOutput("m_payload",   64'(bus_a.m_payload), 64'(exp_pay));
            checkOutput("s_ready",     64'(bus_a.s_ready),   64'(exp_ready));
            checkOutput("err_timeout", 64'(err_a),           64'(mdl_err));
        end
    endtask

    // Move the model across the coming rising edge using the inputs that are
    // being held for it.
    task automatic advanceModelA();
        logic [NA-1:0] v;
        logic [NA-1:0] l;
        v = bus_a.s_valid;
        l = bus_a.s_last;
        if (rst_a) begin
            model_ok   = 1'b1;
            mdl_locked = 1'b0;
            mdl_gnt    = 0;
            mdl_last   = NA - 1;
            mdl_beats  = 0;
            mdl_err    = 1'b0;
        end else if (model_ok) begin
            mdl_err = 1'b0;
            if (!mdl_locked) begin
                for (int k = 1; k <= NA; k++) begin
                    int idx;
                    idx = (mdl_last + k) % NA;
                    if (!mdl_locked && v[idx]) begin
                        mdl_gnt    = idx;
                        mdl_locked = 1'b1;
                        mdl_beats  = 0;
                    end
                end
            end else if (v[mdl_gnt] && bus_a.m_ready) begin
                mdl_beats++;
                if (l[mdl_gnt]) begin
                    mdl_locked = 1'b0;
                    mdl_last   = mdl_gnt;
                end else if (mdl_beats == MA) begin
                    mdl_locked = 1'b0;
                    mdl_last   = mdl_gnt;
                    mdl_err    = 1'b1;
                end
            end
        end
    endtask

    // One cycle of instance A: drive just after the falling edge, let the
    // combinational paths settle, check, then advance the model.
    task automatic applyStimulus(input logic rst, input logic [NA-1:0] v,
                                 input logic [NA-1:0] l, input logic rdy);
        @(negedge clk);
        rst_a           = rst;
        bus_a.s_valid   = v;
        bus_a.s_last    = l;
        bus_a.m_ready   = rdy;
        bus_a.s_payload = pay_next;
        #1;
        checkModelA();
        advanceModelA();
    endtask

    task automatic applyStimulusB(input logic rst, input logic [NB-1:0] v);
        @(negedge clk);
        rst_b           = rst;
        bus_b.s_valid   = v;
        bus_b.s_last    = '1;
        bus_b.m_ready   = 1'b1;
        bus_b.s_payload = {8'h22, 8'h11};
        #1;
    endtask

    task automatic randomizePayloads();
        for (int i = 0; i < NA; i++) begin
            pay_next[i*WA +: WA] = $urandom;
        end
    endtask

    // Stimulus sequence: reset, directed scenarios, random traffic, then the
    // two-source instance.
    initial begin
        int err_before;
        int exp_seq[4];
        int pat;
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.s_valid = '0; bus_a.s_last = '0; bus_a.m_ready = 1'b0; bus_a.s_payload = '0;
        bus_b.s_valid = '0; bus_b.s_last = '0; bus_b.m_ready = 1'b0; bus_b.s_payload = '0;
        pay_next = '0;
        randomizePayloads();

        // Reset and the idle values that follow it.
        applyStimulus(1'b1, 6'b000000, 6'b000000, 1'b0);
        applyStimulus(1'b0, 6'b000000, 6'b000000, 1'b0);
        checkOutput("rst_busy",    64'(busy_a),        64'd0);
        checkOutput("rst_m_valid", 64'(bus_a.m_valid), 64'd0);
        checkOutput("rst_m_sel",   64'(bus_a.m_sel),   64'd0);
        checkOutput("rst_s_ready", 64'(bus_a.s_ready), 64'd0);
        checkOutput("rst_err",     64'(err_a),         64'd0);

        // Sources 0, 2, 5 requesting single-beat bursts: order 0,2,5,0 with
        // one idle cycle between grants.
        grant_log.delete();
        busy_log.delete();
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1'b0, 6'b100101, 6'b111111, 1'b1);
        end
        exp_seq = '{0, 2, 5, 0};
        checkOutput("rr_grant_count", 64'(grant_log.size()), 64'd4);
        for (int g = 0; g < 4; g++) begin
            checkOutput("rr_grant_order", 64'((g < grant_log.size()) ? grant_log[g] : -1), 64'(exp_seq[g]));
        end
        pat = 0;
        for (int c = 0; c < busy_log.size(); c++) begin
            pat = pat | (busy_log[c] << c);
        end
        checkOutput("rr_busy_pattern", 64'(pat), 64'hAA);

        // Source 3 four-beat burst while source 1 keeps requesting. The
        // fourth beat is both last and the beat limit, so no timeout.
        applyStimulus(1'b0, 6'b000100, 6'b111111, 1'b1);
        applyStimulus(1'b0, 6'b000100, 6'b111111, 1'b1);
        err_before = err_seen;
        grant_log.delete();
        applyStimulus(1'b0, 6'b001010, 6'b000010, 1'b1);
        checkOutput("b3_idle_busy", 64'(busy_a), 64'd0);
        for (int k = 0; k < 4; k++) begin
            pay_next[3*WA +: WA] = 32'hA0 + 32'(k);
            applyStimulus(1'b0, 6'b001010, (k == 3) ? 6'b001010 : 6'b000010, 1'b1);
            checkOutput("b3_sel",     64'(bus_a.m_sel),     64'd3);
            checkOutput("b3_payload", 64'(bus_a.m_payload), 64'hA0 + 64'(k));
            checkOutput("b3_src1_rdy", 64'(bus_a.s_ready[1]), 64'd0);
        end
        applyStimulus(1'b0, 6'b001010, 6'b001010, 1'b1);
        applyStimulus(1'b0, 6'b001010, 6'b001010, 1'b1);
        checkOutput("b3_next_sel",  64'(bus_a.m_sel), 64'd1);
        checkOutput("b3_next_busy", 64'(busy_a),      64'd1);
        checkOutput("b3_no_err",    64'(err_seen - err_before), 64'd0);

        // Source 2 never sends last: four beats, forced release, one-cycle
        // timeout pulse, then source 4 is next after 2.
        applyStimulus(1'b0, 6'b000100, 6'b000000, 1'b1);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 6'b000100, 6'b000000, 1'b1);
            checkOutput("to_sel", 64'(bus_a.m_sel), 64'd2);
            checkOutput("to_err_during", 64'(err_a), 64'd0);
        end
        applyStimulus(1'b0, 6'b010101, 6'b111111, 1'b1);
        checkOutput("to_err_pulse", 64'(err_a),  64'd1);
        checkOutput("to_released",  64'(busy_a), 64'd0);
        applyStimulus(1'b0, 6'b010101, 6'b111111, 1'b1);
        checkOutput("to_err_clear", 64'(err_a),       64'd0);
        checkOutput("to_next_sel",  64'(bus_a.m_sel), 64'd4);

        // Downstream stall: payload and grant hold, beat count frozen, so the
        // limit is still reached only after four real transfers.
        applyStimulus(1'b0, 6'b000001, 6'b000000, 1'b0);
        pay_next[0 +: WA] = 32'hDEADBEEF;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 6'b000001, 6'b000000, 1'b0);
            checkOutput("stall_payload", 64'(bus_a.m_payload), 64'hDEADBEEF);
            checkOutput("stall_busy",    64'(busy_a),          64'd1);
        end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 6'b000001, 6'b000000, 1'b1);
            checkOutput("stall_hold", 64'(busy_a), 64'd1);
        end
        applyStimulus(1'b0, 6'b000000, 6'b000000, 1'b1);
        checkOutput("stall_err", 64'(err_a), 64'd1);

        // Reset on beat 2 of a source-4 burst.
        applyStimulus(1'b0, 6'b010000, 6'b000000, 1'b1);
        applyStimulus(1'b0, 6'b010000, 6'b000000, 1'b1);
        applyStimulus(1'b1, 6'b010000, 6'b000000, 1'b1);
        applyStimulus(1'b0, 6'b010001, 6'b111111, 1'b1);
        checkOutput("mid_rst_valid", 64'(bus_a.m_valid), 64'd0);
        checkOutput("mid_rst_busy",  64'(busy_a),        64'd0);
        checkOutput("mid_rst_sel",   64'(bus_a.m_sel),   64'd0);
        checkOutput("mid_rst_err",   64'(err_a),         64'd0);
        applyStimulus(1'b0, 6'b010001, 6'b111111, 1'b1);
        checkOutput("post_rst_sel",  64'(bus_a.m_sel),   64'd0);
        checkOutput("post_rst_busy", 64'(busy_a),        64'd1);

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            logic [NA-1:0] v;
            logic [NA-1:0] l;
            randomizePayloads();
            v = NA'($urandom);
            l = NA'($urandom & $urandom);
            applyStimulus(($urandom_range(0, 99) == 0), v, l, ($urandom_range(0, 3) != 0));
        end

        // Two sources, both always requesting single-beat bursts.
        applyStimulusB(1'b1, 2'b11);
        for (int c = 1; c <= 8; c++) begin
            applyStimulusB(1'b0, 2'b11);
            if (c % 2 == 0) begin
                int exp_src;
                exp_src = ((c / 2) - 1) % 2;
                checkOutput("alt_busy",    64'(busy_b),          64'd1);
                checkOutput("alt_sel",     64'(bus_b.m_sel),     64'(exp_src));
                checkOutput("alt_payload", 64'(bus_b.m_payload), (exp_src == 0) ? 64'h11 : 64'h22);
            end else begin
                checkOutput("alt_idle", 64'(busy_b), 64'd0);
            end
            checkOutput("alt_err", 64'(err_b), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
